// File: rtl/sky_pkg.sv
// rtl/sky_pkg.sv - shared state encodings, palette sets and band boundaries for the sky path
package sky_pkg;

    typedef enum logic [1:0] {
        ST_DAY    = 2'd0,
        ST_FADE_N = 2'd1,
        ST_NIGHT  = 2'd2,
        ST_FADE_D = 2'd3
    } sky_state_e;

    localparam int NUM_BANDS = 5;

    // Index 0 is the top band.
    localparam logic [NUM_BANDS-1:0][11:0] DAY_PAL   = {12'h3BE, 12'h2AD, 12'h29C, 12'h28A, 12'h168};
    localparam logic [NUM_BANDS-1:0][11:0] NIGHT_PAL = {12'h147, 12'h136, 12'h025, 12'h024, 12'h013};

    // Scanline boundaries between bands, consumed by the sky pixel generator.
    localparam logic [NUM_BANDS:0][8:0] BAND_Y = {9'd375, 9'd236, 9'd136, 9'd61, 9'd21, 9'd0};

    function automatic logic [3:0] nibble_toward(input logic [3:0] cur, input logic [3:0] tgt);
        if (cur < tgt) begin
            return cur + 4'd1;
        end else if (cur > tgt) begin
            return cur - 4'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/sky_fade_step.sv
// rtl/sky_fade_step.sv - one fade step of a 12-bit colour toward its target, with done flag
module sky_fade_step
    import sky_pkg::*;
(
    input  logic [11:0] cur,
    input  logic [11:0] target,
    output logic [11:0] col_next,
    output logic        done
);

    always_comb begin
        col_next = cur;
        for (int i = 0; i < 3; i++) begin
            col_next[4*i +: 4] = nibble_toward(cur[4*i +: 4], target[4*i +: 4]);
        end
    end

    assign done = (col_next == target);

endmodule

// File: rtl/sky_cycle_ctrl.sv
// rtl/sky_cycle_ctrl.sv - day/night sky palette sequencer; SKY_SKIP_EN adds skip_req fast-forward
module sky_cycle_ctrl
    import sky_pkg::*;
#(
    parameter int unsigned DAY_FRAMES   = 1800,
    parameter int unsigned NIGHT_FRAMES = 1200,
    parameter int unsigned FADE_RATE    = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        freeze,
`ifdef SKY_SKIP_EN
    input  logic        skip_req,
`endif
    output logic [11:0] pal0,
    output logic [11:0] pal1,
    output logic [11:0] pal2,
    output logic [11:0] pal3,
    output logic [11:0] pal4,
    output logic [1:0]  state,
    output logic        is_night,
    output logic        phase_pulse
);

    localparam logic [CNT_W-1:0] DAY_LAST   = CNT_W'(DAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] NIGHT_LAST = CNT_W'(NIGHT_FRAMES - 1);
    localparam logic [CNT_W-1:0] FADE_LAST  = CNT_W'(FADE_RATE - 1);

    sky_state_e                      state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_BANDS-1:0][11:0]      pal_q, pal_d;
    logic [NUM_BANDS-1:0][11:0]      fade_target, step_pal;
    logic [NUM_BANDS-1:0]            step_done;
    logic                            pulse_q, pulse_d;
    logic                            tick, skip;

    // A frozen tick is dropped, never deferred.
    assign tick = frame_tick & ~freeze;

`ifdef SKY_SKIP_EN
    assign skip = skip_req;
`else
    assign skip = 1'b0;
`endif

    assign fade_target = (state_q == ST_FADE_D) ? DAY_PAL : NIGHT_PAL;

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        sky_fade_step u_step (
            .cur      (pal_q[b]),
            .target   (fade_target[b]),
            .col_next (step_pal[b]),
            .done     (step_done[b])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pal_d   = pal_q;
        pulse_d = 1'b0;
        if (tick) begin
            case (state_q)
                ST_DAY, ST_NIGHT: begin
                    if (skip || cnt_q == ((state_q == ST_DAY) ? DAY_LAST : NIGHT_LAST)) begin
                        cnt_d   = '0;
                        state_d = (state_q == ST_DAY) ? ST_FADE_N : ST_FADE_D;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == FADE_LAST) begin
                        cnt_d = '0;
                        pal_d = step_pal;
                        if (&step_done) begin
                            state_d = (state_q == ST_FADE_N) ? ST_NIGHT : ST_DAY;
                            pulse_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DAY;
            cnt_q   <= '0;
            pal_q   <= DAY_PAL;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pal_q   <= pal_d;
            pulse_q <= pulse_d;
        end
    end

    assign pal0        = pal_q[0];
    assign pal1        = pal_q[1];
    assign pal2        = pal_q[2];
    assign pal3        = pal_q[3];
    assign pal4        = pal_q[4];
    assign state       = state_q;
    assign is_night    = (state_q == ST_NIGHT);
    assign phase_pulse = pulse_q;

endmodule

// File: tb/tb_sky_cycle_ctrl.sv
// tb/tb_sky_cycle_ctrl.sv - self-checking bench for sky_cycle_ctrl
module tb_sky_cycle_ctrl;

    localparam int DAY_F   = 4;
    localparam int NIGHT_F = 3;
    localparam int FADE_R  = 2;
`ifdef SKY_SKIP_EN
    localparam bit SKIP_ON = 1'b1;
`else
    localparam bit SKIP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        freeze = 1'b0;
    logic        skip_req = 1'b0;
    logic [11:0] pal0, pal1, pal2, pal3, pal4;
    logic [1:0]  state;
    logic        is_night, phase_pulse;

    always #5 clk = ~clk;

    sky_cycle_ctrl #(
        .DAY_FRAMES   (DAY_F),
        .NIGHT_FRAMES (NIGHT_F),
        .FADE_RATE    (FADE_R),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .freeze      (freeze),
`ifdef SKY_SKIP_EN
        .skip_req    (skip_req),
`endif
        .pal0        (pal0),
        .pal1        (pal1),
        .pal2        (pal2),
        .pal3        (pal3),
        .pal4        (pal4),
        .state       (state),
        .is_night    (is_night),
        .phase_pulse (phase_pulse)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase index 0..3 advancing cyclically, palette as nibble arrays.
    int DAY_SET[5][3]   = '{'{1, 6, 8}, '{2, 8, 'hA}, '{2, 9, 'hC}, '{2, 'hA, 'hD}, '{3, 'hB, 'hE}};
    int NIGHT_SET[5][3] = '{'{0, 1, 3}, '{0, 2, 4}, '{0, 2, 5}, '{1, 3, 6}, '{1, 4, 7}};
    int m_state, m_cnt, m_pulse;
    int m_pal[5][3];

    function automatic void model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_pulse = 0;
        m_pal   = DAY_SET;
    endfunction

    function automatic int colour(input int b);
        return m_pal[b][0] * 256 + m_pal[b][1] * 16 + m_pal[b][2];
    endfunction

    function automatic void model_step(input bit ft, input bit fz, input bit sk);
        int limit, tgt;
        bit same;
        m_pulse = 0;
        if (!ft || fz) return;
        m_cnt++;
        if (m_state == 0 || m_state == 2) begin
            limit = (m_state == 0) ? DAY_F : NIGHT_F;
            if (m_cnt == limit || (sk && SKIP_ON)) begin
                m_cnt   = 0;
                m_state = m_state + 1;
                m_pulse = 1;
            end
        end else if (m_cnt == FADE_R) begin
            m_cnt = 0;
            same  = 1;
            for (int b = 0; b < 5; b++) begin
                for (int c = 0; c < 3; c++) begin
                    tgt = (m_state == 1) ? NIGHT_SET[b][c] : DAY_SET[b][c];
                    if (m_pal[b][c] < tgt) m_pal[b][c]++;
                    else if (m_pal[b][c] > tgt) m_pal[b][c]--;
                    if (m_pal[b][c] != tgt) same = 0;
                end
            end
            if (same) begin
                m_state = (m_state + 1) % 4;
                m_pulse = 1;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_pal0"}, pal0, colour(0));
        chk({tag, "_pal1"}, pal1, colour(1));
        chk({tag, "_pal2"}, pal2, colour(2));
        chk({tag, "_pal3"}, pal3, colour(3));
        chk({tag, "_pal4"}, pal4, colour(4));
        chk({tag, "_state"}, state, m_state);
        chk({tag, "_is_night"}, is_night, m_state == 2);
        chk({tag, "_pulse"}, phase_pulse, m_pulse);
    endtask

    task automatic cycle(input bit ft, input bit fz, input bit sk);
        @(negedge clk);
        frame_tick = ft;
        freeze     = fz;
        skip_req   = sk;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        skip_req   = 1'b0;
        model_step(ft, fz, sk);
    endtask

    typedef struct {
        bit          ft;
        bit          fz;
        logic [1:0]  st;
        logic [11:0] p0;
        logic [11:0] p4;
        bit          pp;
    } vec_t;

    vec_t vq[$];

    initial begin
        int npulse;
        // Reset through DAY, full fade to NIGHT (one frozen tick inside), NIGHT into FADE_D.
        vq.push_back(vec_t'{1, 0, 2'd0, 12'h168, 12'h3BE, 0});
        vq.push_back(vec_t'{1, 0, 2'd0, 12'h168, 12'h3BE, 0});
        vq.push_back(vec_t'{1, 0, 2'd0, 12'h168, 12'h3BE, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h168, 12'h3BE, 1});
        vq.push_back(vec_t'{0, 0, 2'd1, 12'h168, 12'h3BE, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h168, 12'h3BE, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h057, 12'h2AD, 0});
        vq.push_back(vec_t'{1, 1, 2'd1, 12'h057, 12'h2AD, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h057, 12'h2AD, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h046, 12'h19C, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h046, 12'h19C, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h035, 12'h18B, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h035, 12'h18B, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h024, 12'h17A, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h024, 12'h17A, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h013, 12'h169, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h013, 12'h169, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h013, 12'h158, 0});
        vq.push_back(vec_t'{1, 0, 2'd1, 12'h013, 12'h158, 0});
        vq.push_back(vec_t'{1, 0, 2'd2, 12'h013, 12'h147, 1});
        vq.push_back(vec_t'{0, 0, 2'd2, 12'h013, 12'h147, 0});
        vq.push_back(vec_t'{1, 0, 2'd2, 12'h013, 12'h147, 0});
        vq.push_back(vec_t'{1, 0, 2'd2, 12'h013, 12'h147, 0});
        vq.push_back(vec_t'{1, 0, 2'd3, 12'h013, 12'h147, 1});

        model_reset();
        #12;
        chk("reset_pal0", pal0, 12'h168);
        chk("reset_pal4", pal4, 12'h3BE);
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            cycle(vq[i].ft, vq[i].fz, 1'b0);
            chk("vec_state", state, vq[i].st);
            chk("vec_pal0", pal0, vq[i].p0);
            chk("vec_pal4", pal4, vq[i].p4);
            chk("vec_pulse", phase_pulse, vq[i].pp);
            check_all("vec_model");
        end

        // FADE_D back to DAY: entry pulse already seen, exactly one more expected.
        npulse = phase_pulse;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            npulse += phase_pulse;
            check_all("fade_d");
        end
        chk("fade_d_pulses", npulse, 2);
        chk("day_state", state, 2'd0);
        chk("day_pal0", pal0, 12'h168);
        chk("day_pal1", pal1, 12'h28A);
        chk("day_pal2", pal2, 12'h29C);
        chk("day_pal3", pal3, 12'h2AD);
        chk("day_pal4", pal4, 12'h3BE);

        // Freeze mid-fade with the fade counter part-way through a step.
        for (int i = 0; i < DAY_F + 3; i++) cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check_all("freeze");
        end
        chk("freeze_pal0", pal0, 12'h057);
        chk("freeze_state", state, 2'd1);
        cycle(1'b1, 1'b0, 1'b0);
        chk("resume_pal0", pal0, 12'h046);
        check_all("resume");

        // Asynchronous reset between clock edges during FADE_N.
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_pal0", pal0, 12'h168);
        chk("areset_pal4", pal4, 12'h3BE);
        chk("areset_state", state, 2'd0);
        check_all("areset");
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SKY_SKIP_EN
        cycle(1'b1, 1'b0, 1'b1);
        chk("skip_state", state, 2'd1);
        chk("skip_pulse", phase_pulse, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        chk("skip_in_fade", state, 2'd1);
        check_all("skip");
`endif

        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0));
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
